// File: rtl/fmult_accum_seq.sv
// fmult_accum_seq: G.726 predictor sum engine; one time-shared FMULT accumulates NZ zero taps then NP pole taps
// into a 16-bit wrapping accumulator and reports sez/se with a start/busy/done handshake.
module fmult_accum_seq #(
    parameter int NZ   = 6,
    parameter int NP   = 2,
    parameter int PIPE = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [16*NZ-1:0]                b_bus,
    input  logic [11*NZ-1:0]                dq_bus,
    input  logic [16*(NP > 0 ? NP : 1)-1:0] a_bus,
    input  logic [11*(NP > 0 ? NP : 1)-1:0] sr_bus,
    output logic                            busy,
    output logic                            done,
    output logic [15:0]                     wa,
    output logic                            wa_valid,
    output logic [14:0]                     sez,
    output logic [14:0]                     se
);
    localparam int NPP = NP > 0 ? NP : 1;

    typedef enum logic [2:0] {S_IDLE, S_ZERO, S_POLE, S_FLUSH, S_FIN} state_t;

    state_t            r_state;
    logic [16*NZ-1:0]  r_b;
    logic [11*NZ-1:0]  r_dq;
    logic [16*NPP-1:0] r_a;
    logic [11*NPP-1:0] r_sr;
    logic [3:0]        r_idx;
    logic [15:0]       r_acc, r_sezi, r_wa;
    logic [14:0]       r_sez, r_se;
    logic              r_v, r_lz, r_lp, r_busy, r_done;

    logic        w_pole, w_v, w_lz, w_lp, w_av, w_alz, w_alp;
    logic [15:0] w_an, w_prod, w_ap, w_sum, w_sezn;
    logic [10:0] w_srv;

    function automatic logic [15:0] fmult(input logic [15:0] an, input logic [10:0] sr);
        logic [12:0] mag;
        logic [3:0]  ex;
        logic [5:0]  mant;
        logic [4:0]  we;
        logic [7:0]  wm;
        logic [16:0] wsh;
        mag = an[15] ? 13'((~an + 16'd1) >> 2) : an[14:2];
        ex = 4'd0;
        for (int k = 0; k < 13; k++)
            if (mag[k]) ex = 4'(k + 1);
        mant = (mag == 13'd0) ? 6'd32 : 6'({mag, 6'b0} >> ex);
        we   = {1'b0, sr[9:6]} + {1'b0, ex};
        wm   = 8'((12'(sr[5:0]) * 12'(mant) + 12'd48) >> 4);
        wsh  = (we <= 5'd26) ? {2'b0, {wm, 7'b0} >> (5'd26 - we)} : {2'b0, wm, 7'b0} << (we - 5'd26);
        return (sr[10] ^ an[15]) ? 16'(-{1'b0, wsh[14:0]}) : {1'b0, wsh[14:0]};
    endfunction

    always_comb begin
        w_pole = r_state == S_POLE;
        w_v    = r_state == S_ZERO || w_pole;
        w_lz   = r_state == S_ZERO && r_idx == 4'(NZ - 1);
        w_lp   = NP == 0 ? w_lz : (w_pole && r_idx == 4'(NPP - 1));
        w_an   = w_pole ? r_a[16*r_idx +: 16] : r_b[16*r_idx +: 16];
        w_srv  = w_pole ? r_sr[11*r_idx +: 11] : r_dq[11*r_idx +: 11];
        w_prod = fmult(w_an, w_srv);
        // With PIPE the accumulator consumes the registered product and its delayed tags
        w_av   = PIPE != 0 ? r_v : w_v;
        w_alz  = PIPE != 0 ? r_lz : w_lz;
        w_alp  = PIPE != 0 ? r_lp : w_lp;
        w_ap   = PIPE != 0 ? r_wa : w_prod;
        w_sum  = r_acc + w_ap;
        w_sezn = w_alz ? w_sum : r_sezi;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_b     <= '0;
            r_dq    <= '0;
            r_a     <= '0;
            r_sr    <= '0;
            r_idx   <= '0;
            r_acc   <= '0;
            r_sezi  <= '0;
            r_wa    <= '0;
            r_sez   <= '0;
            r_se    <= '0;
            r_v     <= 1'b0;
            r_lz    <= 1'b0;
            r_lp    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_v    <= w_v;
            r_lz   <= w_lz;
            r_lp   <= w_lp;
            if (w_v) r_wa <= w_prod;
            if (w_av) r_acc <= w_sum;
            if (w_av && w_alz) r_sezi <= w_sum;
            if (w_av && w_alp) begin
                r_sez  <= w_sezn[15:1];
                r_se   <= w_sum[15:1];
                r_done <= 1'b1;
            end
            case (r_state)
                S_IDLE, S_FIN: begin
                    if (start) begin
                        r_b     <= b_bus;
                        r_dq    <= dq_bus;
                        r_a     <= a_bus;
                        r_sr    <= sr_bus;
                        r_acc   <= '0;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_ZERO;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ZERO: begin
                    r_idx <= w_lz ? 4'd0 : r_idx + 4'd1;
                    if (w_lz) begin
                        r_busy  <= NP > 0 || PIPE != 0;
                        r_state <= NP > 0 ? S_POLE : PIPE != 0 ? S_FLUSH : S_FIN;
                    end
                end
                S_POLE: begin
                    r_idx <= w_lp ? 4'd0 : r_idx + 4'd1;
                    if (w_lp) begin
                        r_busy  <= PIPE != 0;
                        r_state <= PIPE != 0 ? S_FLUSH : S_FIN;
                    end
                end
                S_FLUSH: begin
                    r_busy  <= 1'b0;
                    r_state <= S_FIN;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign wa       = PIPE != 0 ? r_wa : (w_v ? w_prod : r_wa);
    assign wa_valid = w_av;
    assign sez      = r_sez;
    assign se       = r_se;
endmodule

// File: tb/tb_fmult_accum_seq.sv
// tb_fmult_accum_seq: directed and randomized runs of the predictor-sum engine against an arithmetic
// reference model; covers the default build and an NZ=3/NP=0/PIPE=1 build.
module tb_fmult_accum_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, start2;
    logic [95:0] b_bus;
    logic [65:0] dq_bus;
    logic [31:0] a_bus;
    logic [21:0] sr_bus;
    logic        busy, done, wa_valid;
    logic [15:0] wa;
    logic [14:0] sez, se;

    logic [47:0] b2;
    logic [32:0] dq2;
    logic        busy2, done2, wa_valid2;
    logic [15:0] wa2;
    logic [14:0] sez2, se2;

    int n_chk = 0;
    int n_pass = 0;
    int m_p[16];
    int m_sez, m_se;

    fmult_accum_seq u_dut (
        .clk(clk), .reset(reset), .start(start), .b_bus(b_bus), .dq_bus(dq_bus),
        .a_bus(a_bus), .sr_bus(sr_bus), .busy(busy), .done(done), .wa(wa),
        .wa_valid(wa_valid), .sez(sez), .se(se)
    );

    fmult_accum_seq #(.NZ(3), .NP(0), .PIPE(1)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .b_bus(b2), .dq_bus(dq2),
        .a_bus(16'h0000), .sr_bus(11'h000), .busy(busy2), .done(done2), .wa(wa2),
        .wa_valid(wa_valid2), .sez(sez2), .se(se2)
    );

    function automatic int ref_fmult(input int an, input int sr);
        int s, mag, ex, mant, we, wm, wmag;
        s    = (an >> 15) & 1;
        mag  = s ? ((-an) >> 2) & 'h1FFF : an >> 2;
        ex   = 0;
        while ((1 << ex) <= mag) ex++;
        mant = (mag == 0) ? 32 : (mag << 6) >> ex;
        we   = ((sr >> 6) & 15) + ex;
        wm   = ((sr & 63) * mant + 48) >> 4;
        wmag = (we <= 26) ? (wm << 7) >> (26 - we) : ((wm << 7) << (we - 26)) & 'h7FFF;
        return ((((sr >> 10) & 1) ^ s) != 0) ? (-wmag) & 'hFFFF : wmag;
    endfunction

    task automatic model(input int nz, input int np, input logic [127:0] bb, input logic [87:0] dd,
                         input logic [63:0] aa, input logic [43:0] ss);
        int acc, sezi;
        acc = 0;
        for (int i = 0; i < nz; i++) begin
            m_p[i] = ref_fmult(int'(bb[16*i +: 16]), int'(dd[11*i +: 11]));
            acc = (acc + m_p[i]) & 'hFFFF;
        end
        sezi = acc;
        for (int j = 0; j < np; j++) begin
            m_p[nz+j] = ref_fmult(int'(aa[16*j +: 16]), int'(ss[11*j +: 11]));
            acc = (acc + m_p[nz+j]) & 'hFFFF;
        end
        m_sez = sezi >> 1;
        m_se  = acc >> 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic rand1();
        for (int i = 0; i < 6; i++) begin
            b_bus[16*i +: 16] = 16'($urandom);
            dq_bus[11*i +: 11] = 11'($urandom);
        end
        for (int j = 0; j < 2; j++) begin
            a_bus[16*j +: 16] = 16'($urandom);
            sr_bus[11*j +: 11] = 11'($urandom);
        end
    endtask

    task automatic clear1();
        b_bus = '0; dq_bus = '0; a_bus = '0; sr_bus = '0;
    endtask

    task automatic go1();
        @(negedge clk);
        model(6, 2, 128'(b_bus), 88'(dq_bus), 64'(a_bus), 44'(sr_bus));
        start = 1'b1;
    endtask

    // Cycle n counts negedges after the accepting edge; FIN (done) is cycle NZ+NP+1 = 9
    task automatic run1(input string tag, input bit mid, input bit chg, input bit hold);
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            chk({tag, "/busy"}, 32'(busy), 32'(n <= 8));
            chk({tag, "/done"}, 32'(done), 32'(n == 9));
            chk({tag, "/wa_valid"}, 32'(wa_valid), 32'(n <= 8));
            if (n <= 8) chk({tag, "/wa"}, 32'(wa), m_p[n-1]);
            if (n == 9) begin
                chk({tag, "/sez"}, 32'(sez), m_sez);
                chk({tag, "/se"}, 32'(se), m_se);
            end
            if (n == 1) start = 1'b0;
            if (chg && n == 1) rand1();
            if (mid && n == 3) start = 1'b1;
            if (mid && n == 4) start = 1'b0;
            if (hold && n == 9) begin
                rand1();
                model(6, 2, 128'(b_bus), 88'(dq_bus), 64'(a_bus), 44'(sr_bus));
                start = 1'b1;
            end
        end
    endtask

    // NZ=3, NP=0, PIPE=1: products visible one cycle late, done at cycle 3+0+1+1 = 5
    task automatic run2(input string tag);
        @(negedge clk);
        model(3, 0, 128'(b2), 88'(dq2), 64'(0), 44'(0));
        start2 = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            chk({tag, "/busy"}, 32'(busy2), 32'(n <= 4));
            chk({tag, "/done"}, 32'(done2), 32'(n == 5));
            chk({tag, "/wa_valid"}, 32'(wa_valid2), 32'(n >= 2 && n <= 4));
            if (n >= 2 && n <= 4) chk({tag, "/wa"}, 32'(wa2), m_p[n-2]);
            if (n == 5) begin
                chk({tag, "/sez"}, 32'(sez2), m_sez);
                chk({tag, "/se"}, 32'(se2), m_sez);
            end
            if (n == 1) start2 = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; start2 = 1'b0;
        clear1();
        b2 = '0; dq2 = '0;
        repeat (3) @(negedge clk);
        chk("rst/busy", 32'(busy), 0);
        chk("rst/done", 32'(done), 0);
        chk("rst/wa", 32'(wa), 0);
        chk("rst/wa_valid", 32'(wa_valid), 0);
        chk("rst/sez", 32'(sez), 0);
        chk("rst/se", 32'(se), 0);
        chk("rst/done2", 32'(done2), 0);
        reset = 1'b0;

        clear1(); go1(); run1("all_zero", 0, 0, 0);

        clear1(); b_bus[15:0] = 16'h4000; dq_bus[10:0] = {1'b0, 4'd10, 6'd32};
        go1(); run1("b_pos", 0, 0, 0);
        chk("b_pos/wa_const", 32'(m_p[0]), 32'h0430);
        chk("b_pos/sez_const", 32'(sez), 32'h0218);
        chk("b_pos/se_const", 32'(se), 32'h0218);

        b_bus[15:0] = 16'hC000;
        go1(); run1("b_neg", 0, 0, 0);
        chk("b_neg/sez_const", 32'(sez), 32'h7DE8);
        chk("b_neg/se_const", 32'(se), 32'h7DE8);

        clear1(); a_bus[15:0] = 16'h4000; sr_bus[10:0] = {1'b0, 4'd10, 6'd32};
        go1(); run1("pole_only", 0, 0, 0);
        chk("pole_only/sez_const", 32'(sez), 32'h0000);
        chk("pole_only/se_const", 32'(se), 32'h0218);

        for (int i = 0; i < 6; i++) begin
            b_bus[16*i +: 16] = 16'h7000; dq_bus[11*i +: 11] = {1'b0, 4'd15, 6'd63};
        end
        for (int j = 0; j < 2; j++) begin
            a_bus[16*j +: 16] = 16'h7000; sr_bus[11*j +: 11] = {1'b0, 4'd15, 6'd63};
        end
        go1(); run1("wrap", 0, 0, 0);
        chk("wrap/sez_const", 32'(sez), 32'h3A00);
        chk("wrap/se_const", 32'(se), 32'h7800);

        repeat (4) begin
            rand1(); go1(); run1("rand", 0, 0, 0);
        end

        rand1(); go1(); run1("mid_start_bus_change", 1, 1, 0);

        rand1(); go1(); run1("chain_a", 0, 0, 1);
        run1("chain_b", 0, 0, 0);

        rand1(); go1();
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        chk("abort/busy", 32'(busy), 0);
        chk("abort/done", 32'(done), 0);
        chk("abort/wa", 32'(wa), 0);
        chk("abort/wa_valid", 32'(wa_valid), 0);
        chk("abort/sez", 32'(sez), 0);
        chk("abort/se", 32'(se), 0);
        reset = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            chk("abort/no_done", 32'(done), 0);
        end

        b2 = '0; dq2 = '0; b2[15:0] = 16'h4000; dq2[10:0] = {1'b0, 4'd10, 6'd32};
        run2("np0_dir");
        chk("np0_dir/sez_const", 32'(sez2), 32'h0218);
        repeat (5) begin
            for (int i = 0; i < 3; i++) begin
                b2[16*i +: 16] = 16'($urandom);
                dq2[11*i +: 11] = 11'($urandom);
            end
            run2("np0_rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
